// File: rtl/lif_neuron_scheduler.sv
// Time-multiplexes NUM_NEURONS virtual LIF neurons onto one external core, one neuron per 3 cycles.
// Optional per-neuron refractory counters are built when LIF_SCHED_REFRACTORY_EN is defined.
module lif_neuron_scheduler #(
  parameter int NUM_NEURONS = 4,
  parameter int AW          = $clog2(NUM_NEURONS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   start,
  input  logic                   clear,
  input  logic [7:0]             spike_in,
  input  logic [3:0]             tref,
  output logic                   busy,
  output logic                   done,
  output logic [NUM_NEURONS-1:0] spike_out_vec,
  output logic                   weight_rd_en,
  output logic [AW-1:0]          weight_addr,
  input  logic [63:0]            weight_data,
  output logic                   core_en,
  output logic [7:0]             core_spike_in,
  output logic [63:0]            core_weight,
  output logic [7:0]             core_memb_in,
  input  logic [7:0]             core_memb_out,
  input  logic                   core_spike_out
);

  typedef enum logic [2:0] {IDLE, FETCH, ISSUE, CAPTURE, DONE} state_t;

  state_t        state, state_nxt;
  logic [AW-1:0] idx;
  logic [7:0]    spk_reg;
  logic [7:0]    mem [NUM_NEURONS];
  logic          last;

`ifdef LIF_SCHED_REFRACTORY_EN
  logic [3:0]    ref_cnt [NUM_NEURONS];
`else
  logic          unused_tref;
  assign unused_tref = ^tref;
`endif

  assign last = (idx == AW'(NUM_NEURONS - 1));

  // Core-facing outputs are gated to their own state so they read as 0 everywhere else.
  always_comb begin
    state_nxt     = state;
    busy          = 1'b0;
    done          = 1'b0;
    weight_rd_en  = 1'b0;
    weight_addr   = '0;
    core_en       = 1'b0;
    core_spike_in = '0;
    core_weight   = '0;
    core_memb_in  = '0;
    case (state)
      IDLE:    if (start && !clear) state_nxt = FETCH;
      FETCH: begin
        busy         = 1'b1;
        weight_rd_en = 1'b1;
        weight_addr  = idx;
        state_nxt    = ISSUE;
      end
      ISSUE: begin
        busy          = 1'b1;
        core_en       = 1'b1;
        core_spike_in = spk_reg;
        core_weight   = weight_data;
        core_memb_in  = mem[idx];
        state_nxt     = CAPTURE;
      end
      CAPTURE: begin
        busy      = 1'b1;
        state_nxt = last ? DONE : FETCH;
      end
      DONE: begin
        busy      = 1'b1;
        done      = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= IDLE;
      idx           <= '0;
      spk_reg       <= '0;
      spike_out_vec <= '0;
      for (int i = 0; i < NUM_NEURONS; i++) begin
        mem[i] <= '0;
`ifdef LIF_SCHED_REFRACTORY_EN
        ref_cnt[i] <= '0;
`endif
      end
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (clear) begin
            spike_out_vec <= '0;
            for (int i = 0; i < NUM_NEURONS; i++) begin
              mem[i] <= '0;
`ifdef LIF_SCHED_REFRACTORY_EN
              ref_cnt[i] <= '0;
`endif
            end
          end else if (start) begin
            spk_reg <= spike_in;
            idx     <= '0;
          end
        end
        CAPTURE: begin
`ifdef LIF_SCHED_REFRACTORY_EN
          // A refractory neuron is held at rest; whatever the core computed is dropped.
          if (ref_cnt[idx] != 4'd0) begin
            mem[idx]           <= '0;
            spike_out_vec[idx] <= 1'b0;
            ref_cnt[idx]       <= ref_cnt[idx] - 4'd1;
          end else begin
            mem[idx]           <= core_memb_out;
            spike_out_vec[idx] <= core_spike_out;
            if (core_spike_out) ref_cnt[idx] <= tref;
          end
`else
          mem[idx]           <= core_memb_out;
          spike_out_vec[idx] <= core_spike_out;
`endif
          if (!last) idx <= idx + AW'(1);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lif_neuron_scheduler.sv
// Directed bench for lif_neuron_scheduler: table of timesteps plus reset/clear/start corner sequences.
module tb_lif_neuron_scheduler;
  localparam int N = 4;

  logic          clk = 1'b0, reset = 1'b1, start = 1'b0, clear = 1'b0;
  logic [7:0]    spike_in = '0;
  logic [3:0]    tref = '0;
  logic          busy, done, weight_rd_en, core_en;
  logic [N-1:0]  spike_out_vec;
  logic [1:0]    weight_addr;
  logic [63:0]   weight_data = '0;
  logic [7:0]    core_spike_in, core_memb_in;
  logic [63:0]   core_weight;
  logic [7:0]    core_memb_out = '0;
  logic          core_spike_out = 1'b0;

  always #5 clk = ~clk;

  lif_neuron_scheduler #(.NUM_NEURONS(N)) dut (
    .clk(clk), .reset(reset), .start(start), .clear(clear), .spike_in(spike_in), .tref(tref),
    .busy(busy), .done(done), .spike_out_vec(spike_out_vec), .weight_rd_en(weight_rd_en),
    .weight_addr(weight_addr), .weight_data(weight_data), .core_en(core_en),
    .core_spike_in(core_spike_in), .core_weight(core_weight), .core_memb_in(core_memb_in),
    .core_memb_out(core_memb_out), .core_spike_out(core_spike_out)
  );

  // Weight word for neuron k tags every byte with k so the core can tell which neuron it serves.
  function automatic logic [63:0] wval(input int k);
    return {8{8'hA0 | 8'(k)}};
  endfunction

  logic [3:0] spk_mask   = '0;
  logic       rst_on_spk = 1'b0;

  always @(posedge clk) if (weight_rd_en) weight_data <= wval(int'(weight_addr));
  always @(posedge clk)
    if (core_en) begin
      core_spike_out <= spk_mask[core_weight[1:0]];
      core_memb_out  <= (rst_on_spk && spk_mask[core_weight[1:0]]) ? 8'h00 : core_memb_in + 8'd5;
    end

  int errors = 0, checks = 0;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  int         lat, ndone, nfetch, nissue, bad_pt, nb;
  logic [7:0] addr_seq;
  logic [7:0] obs_memb [4];
  logic       busy1, busy_end, zero_ok;
  logic [3:0] svec_done;

  // mode 0: plain timestep; 1: extra starts in cycles 2 and 5; 2: reset in cycle 7.
  task automatic run_ts(input logic [7:0] sin, input logic [3:0] mask, input int mode);
    spike_in = sin; spk_mask = mask;
    lat = -1; ndone = 0; nfetch = 0; nissue = 0; bad_pt = 0; addr_seq = '0;
    busy1 = 1'b0; busy_end = 1'b1; zero_ok = 1'b0; svec_done = '0;
    for (int k = 0; k < 4; k++) obs_memb[k] = 8'hEE;
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    for (int i = 1; i <= 30; i++) begin
      @(negedge clk);
      if (i == 1) busy1 = busy;
      if (weight_rd_en) begin addr_seq = {addr_seq[5:0], weight_addr}; nfetch++; end
      if (core_en) begin
        if (nissue < 4) obs_memb[nissue] = core_memb_in;
        if (core_spike_in !== sin || core_weight !== wval(nissue)) bad_pt++;
        nissue++;
      end
      if (done) begin
        ndone++;
        if (lat < 0) begin lat = i; svec_done = spike_out_vec; end
      end
      if (mode == 2 && i == 8)
        zero_ok = ({busy, done, weight_rd_en, core_en, core_spike_in, core_weight,
                    core_memb_in, spike_out_vec, weight_addr} == '0);
      if (i == 30) busy_end = busy;
      if (mode == 1) start = (i == 2 || i == 5);
      if (mode == 2) reset = (i == 7);
    end
    start = 1'b0;
  endtask

  typedef struct {
    logic [7:0] sin;
    logic [3:0] mask;
    logic       pre_clr;
    logic [7:0] memb;
    logic [3:0] svec;
  } vec_t;
  vec_t tbl [5];

`ifdef LIF_SCHED_REFRACTORY_EN
  localparam logic [3:0] N2_EXP = 4'b1001;
`else
  localparam logic [3:0] N2_EXP = 4'b1111;
`endif

  initial begin
    tbl[0] = '{8'h3C, 4'b0101, 1'b0, 8'h00, 4'b0101};
    tbl[1] = '{8'hFF, 4'b0010, 1'b0, 8'h05, 4'b0010};
    tbl[2] = '{8'h01, 4'b1000, 1'b0, 8'h0A, 4'b1000};
    tbl[3] = '{8'h5A, 4'b0110, 1'b0, 8'h0F, 4'b0110};
    tbl[4] = '{8'h81, 4'b1111, 1'b1, 8'h00, 4'b1111};

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    chk("rst_ctrl", {busy, done, weight_rd_en, core_en}, 4'b0000);
    chk("rst_core", {core_spike_in, core_memb_in, core_weight}, '0);
    chk("rst_svec", spike_out_vec, '0);

    for (int r = 0; r < 5; r++) begin
      if (tbl[r].pre_clr) begin
        @(posedge clk); #1 clear = 1'b1; start = 1'b1;
        @(posedge clk); #1 clear = 1'b0; start = 1'b0;
        nb = 0;
        for (int j = 0; j < 6; j++) begin
          @(negedge clk);
          if (busy || weight_rd_en) nb++;
        end
        chk($sformatf("r%0d_clr_start_idle", r), 64'(nb), 0);
        chk($sformatf("r%0d_clr_svec", r), spike_out_vec, 0);
      end
      run_ts(tbl[r].sin, tbl[r].mask, 0);
      chk($sformatf("r%0d_lat", r), 64'(lat), 13);
      chk($sformatf("r%0d_ndone", r), 64'(ndone), 1);
      chk($sformatf("r%0d_busy1", r), busy1, 1);
      chk($sformatf("r%0d_nfetch", r), 64'(nfetch), 4);
      chk($sformatf("r%0d_addr_seq", r), addr_seq, 8'h1B);
      chk($sformatf("r%0d_memb_in", r), {obs_memb[3], obs_memb[2], obs_memb[1], obs_memb[0]},
          {4{tbl[r].memb}});
      chk($sformatf("r%0d_pass_thru", r), 64'(bad_pt), 0);
      chk($sformatf("r%0d_svec_done", r), svec_done, tbl[r].svec);
      chk($sformatf("r%0d_svec_hold", r), spike_out_vec, tbl[r].svec);
      chk($sformatf("r%0d_busy_end", r), busy_end, 0);
    end

    run_ts(8'h11, 4'b1001, 1);
    chk("dbl_start_ndone", 64'(ndone), 1);
    chk("dbl_start_lat", 64'(lat), 13);
    chk("dbl_start_nfetch", 64'(nfetch), 4);
    chk("dbl_start_busy_end", busy_end, 0);

    run_ts(8'h22, 4'b1111, 2);
    chk("rst_mid_ndone", 64'(ndone), 0);
    chk("rst_mid_zero", zero_ok, 1);
    chk("rst_mid_busy_end", busy_end, 0);
    run_ts(8'h33, 4'b0011, 0);
    chk("post_rst_lat", 64'(lat), 13);
    chk("post_rst_memb", {obs_memb[3], obs_memb[2], obs_memb[1], obs_memb[0]}, 0);
    chk("post_rst_svec", spike_out_vec, 4'b0011);

    @(posedge clk); #1 reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    tref = 4'd2; rst_on_spk = 1'b1;
    for (int t = 0; t < 4; t++) begin
      run_ts(8'h44, 4'b0100, 0);
      chk($sformatf("ref_t%0d_lat", t), 64'(lat), 13);
      chk($sformatf("ref_t%0d_svec2", t), spike_out_vec[2], N2_EXP[t]);
      chk($sformatf("ref_t%0d_memb2", t), obs_memb[2], 8'h00);
      chk($sformatf("ref_t%0d_memb0", t), obs_memb[0], 8'(5 * t));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
